// File: rtl/bmp_pkg.sv
// Shared constants and helpers for the BMP pixel-processing path.
// Imported by the pixel operator and the pixel processor top.
package bmp_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_TH   = 2'b01;
   localparam logic [1:0] MODE_BR   = 2'b10;

   localparam int HEADER_BYTES     = 56;
   localparam int BYTES_PER_PIXEL  = 3;
   localparam int WORDS_PER_GROUP  = 3;
   localparam int PIXELS_PER_GROUP = 4;

   function automatic logic [7:0] sat_add(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/bmp_pixel_processor_pixel_op.sv
// Combinational transform of one 24-bit pixel {B,G,R}.
// A low enable leaves the pixel untouched (incomplete pixel on flush).
module pixel_op
   import bmp_pkg::*;
(
   input  logic [23:0] i_pix,
   input  logic [1:0]  i_mode,
   input  logic [7:0]  i_val,
   input  logic        i_en,
   output logic [23:0] o_pix
);

   logic [9:0] w_sum;
   logic [7:0] w_gray;

   always_comb begin
      w_sum  = {2'b00, i_pix[23:16]}
             + {1'b0, i_pix[15:8], 1'b0}
             + {2'b00, i_pix[7:0]};
      w_gray = w_sum[9:2];
      o_pix  = i_pix;
      if (i_en) begin
         unique case (1'b1)
            (i_mode == MODE_TH):
               o_pix = (w_gray >= i_val) ? 24'hFFFFFF : 24'h000000;
            (i_mode == MODE_BR):
               o_pix = {sat_add(i_pix[23:16], i_val),
                        sat_add(i_pix[15:8], i_val),
                        sat_add(i_pix[7:0], i_val)};
            default:
               o_pix = i_pix;
         endcase
      end
   end

endmodule

// File: rtl/bmp_pixel_processor.sv
// Regroups 32-bit pixel words into 3-word / 4-pixel groups, transforms them
// and streams the results back out one word per cycle in input order.
module bmp_pixel_processor
   import bmp_pkg::*;
#(
   parameter int DATA_BUS_SIZE = 32
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic [7:0]               data_proc,
   input  logic [DATA_BUS_SIZE-1:0] data_to_processor,
   input  logic                     scheduler_2_proc_vld,
   input  logic                     done,
   output logic [DATA_BUS_SIZE-1:0] data_from_processor,
   output logic                     vld_pr,
   output logic                     busy
);

   localparam int GW = DATA_BUS_SIZE * WORDS_PER_GROUP;

   logic [DATA_BUS_SIZE-1:0] r_w0, r_w1;
   logic [DATA_BUS_SIZE-1:0] r_b0, r_b1, r_b2;
   logic [1:0]               r_wcnt, r_ecnt;
   logic [1:0]               r_mode;
   logic [7:0]               r_val;

   logic                     w_last, w_flush;
   logic [GW-1:0]            w_grp, w_res;
   logic [PIXELS_PER_GROUP-1:0] w_en;

   // A flush waits until at most the final pending word remains, so the
   // bank is never overwritten while older words are still queued.
   always_comb begin
      w_last  = scheduler_2_proc_vld && (r_wcnt == 2'd2);
      w_flush = done && !scheduler_2_proc_vld
             && (r_wcnt != 2'd0) && (r_ecnt <= 2'd1);
      w_grp   = {r_w0, r_w1,
                 w_last ? data_to_processor : {DATA_BUS_SIZE{1'b0}}};
      if (w_last)
         w_en = 4'b1111;
      else if (r_wcnt == 2'd2)
         w_en = 4'b0011;
      else
         w_en = 4'b0001;
   end

   for (genvar p = 0; p < PIXELS_PER_GROUP; p++) begin : g_op
      pixel_op u_op (
         .i_pix  (w_grp[GW-1-24*p -: 24]),
         .i_mode (r_mode),
         .i_val  (r_val),
         .i_en   (w_en[p]),
         .o_pix  (w_res[GW-1-24*p -: 24])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_w0   <= '0;
         r_w1   <= '0;
         r_b0   <= '0;
         r_b1   <= '0;
         r_b2   <= '0;
         r_wcnt <= 2'd0;
         r_ecnt <= 2'd0;
         r_mode <= MODE_PASS;
         r_val  <= 8'd0;
      end else begin
         if (r_ecnt != 2'd0) begin
            r_b0   <= r_b1;
            r_b1   <= r_b2;
            r_b2   <= '0;
            r_ecnt <= r_ecnt - 2'd1;
         end
         if (scheduler_2_proc_vld) begin
            if (r_wcnt == 2'd0) begin
               r_w0   <= data_to_processor;
               r_mode <= mode;
               r_val  <= data_proc;
               r_wcnt <= 2'd1;
            end else if (r_wcnt == 2'd1) begin
               r_w1   <= data_to_processor;
               r_wcnt <= 2'd2;
            end else begin
               r_wcnt <= 2'd0;
            end
         end
         if (w_last || w_flush) begin
            r_b0   <= w_res[GW-1 -: DATA_BUS_SIZE];
            r_b1   <= w_res[GW-1-DATA_BUS_SIZE -: DATA_BUS_SIZE];
            r_b2   <= w_res[DATA_BUS_SIZE-1:0];
            r_ecnt <= w_last ? 2'd3 : r_wcnt;
            r_wcnt <= 2'd0;
         end
      end
   end

   assign vld_pr              = (r_ecnt != 2'd0);
   assign data_from_processor = vld_pr ? r_b0 : {DATA_BUS_SIZE{1'b0}};
   assign busy                = (r_wcnt != 2'd0) || (r_ecnt != 2'd0);

endmodule

// File: tb/tb_bmp_pixel_processor.sv
// Self-checking bench for bmp_pixel_processor: group vectors, streaming,
// flush, reset and mid-group mode change, with a scoreboard of output words.
module tb_bmp_pixel_processor;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [7:0]  data_proc;
   logic [31:0] din;
   logic        vld;
   logic        done;
   logic [31:0] dout;
   logic        vld_pr;
   logic        busy;

   always #5 clk = ~clk;

   bmp_pixel_processor #(.DATA_BUS_SIZE(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .mode                 (mode),
      .data_proc            (data_proc),
      .data_to_processor    (din),
      .scheduler_2_proc_vld (vld),
      .done                 (done),
      .data_from_processor  (dout),
      .vld_pr               (vld_pr),
      .busy                 (busy)
   );

   typedef struct {
      logic [1:0]  m;
      logic [7:0]  d;
      logic [95:0] w;
      logic [95:0] e;
   } vec_t;

   vec_t        tbl[8];
   logic [31:0] q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          run = 0;
   int          max_run = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // one clock: sample outputs mid-cycle, then step past the next edge
   task automatic cyc();
      logic [31:0] e;
      @(negedge clk);
      if (vld_pr === 1'b1) begin
         run++;
         if (run > max_run) max_run = run;
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_vld: got %h expected no word", dout);
         end else begin
            e = q.pop_front();
            chk("out_word", dout, e);
         end
      end else begin
         run = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] w, input logic [1:0] m,
                      input logic [7:0] d);
      vld = 1'b1;
      din = w;
      mode = m;
      data_proc = d;
      cyc();
      vld = 1'b0;
   endtask

   task automatic drain(input string nm);
      int c;
      c = 0;
      while (q.size() != 0 && c < 30) begin
         cyc();
         c++;
      end
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d words left expected 0", nm, q.size());
         q.delete();
      end
      cyc();
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      tbl[0] = '{2'b01, 8'h80, {32'hFFFFFF00, 32'h00000080, 32'h80808080},
                               {32'hFFFFFF00, 32'h00000000, 32'h00FFFFFF}};
      tbl[1] = '{2'b10, 8'h10, {32'hF5FA0010, 32'hF5FA0010, 32'hF5FA0010},
                               {32'hFFFF1020, 32'hFFFF1020, 32'hFFFF1020}};
      tbl[2] = '{2'b00, 8'h55, {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C},
                               {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C}};
      tbl[3] = '{2'b11, 8'h20, {32'hDEADBEEF, 32'hCAFEBABE, 32'h01020304},
                               {32'hDEADBEEF, 32'hCAFEBABE, 32'h01020304}};
      tbl[4] = '{2'b01, 8'h00, {32'h00000000, 32'h00000000, 32'h00000000},
                               {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
      tbl[5] = '{2'b01, 8'hFF, {32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF},
                               {32'hFFFFFF00, 32'h0000FFFF, 32'hFFFFFFFF}};
      tbl[6] = '{2'b10, 8'h01, {32'hFF00FE7F, 32'h00000000, 32'hFFFFFFFF},
                               {32'hFF01FF80, 32'h01010101, 32'hFFFFFFFF}};
      tbl[7] = '{2'b01, 8'h40, {32'h008000FF, 32'h00000000, 32'hFF007F02},
                               {32'hFFFFFF00, 32'h00000000, 32'h00FFFFFF}};

      rst = 1'b1;
      vld = 1'b0;
      done = 1'b0;
      mode = 2'b00;
      data_proc = 8'h00;
      din = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_vld", {31'd0, vld_pr}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_data", dout, 32'd0);
      @(posedge clk);
      #1;

      // all groups back to back: output must be one unbroken run
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 3; k++) begin
            q.push_back(tbl[i].e[95-32*k -: 32]);
            put(tbl[i].w[95-32*k -: 32], tbl[i].m, tbl[i].d);
         end
      end
      drain("table");
      chk("stream_run", max_run, 32'd24);

      // flush of a two-word group, bytes 6-7 pass through
      q.push_back(32'hFFFFFFFF);
      q.push_back(32'hFFFF8012);
      put(32'h80808080, 2'b01, 8'h80);
      put(32'h80808012, 2'b01, 8'h80);
      done = 1'b1;
      drain("flush2");
      repeat (4) cyc();
      chk("flush2_hold_busy", {31'd0, busy}, 32'd0);
      done = 1'b0;
      cyc();

      // valid word accepted alongside done, then a one-word flush
      q.push_back(32'hFFFFFF12);
      done = 1'b1;
      put(32'h80808012, 2'b01, 8'h80);
      drain("flush1");
      done = 1'b0;
      cyc();

      // reset discards a partial group
      put(32'hAAAAAAAA, 2'b10, 8'h10);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_vld", {31'd0, vld_pr}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         q.push_back(32'hFFFF1020);
         put(32'hF5FA0010, 2'b10, 8'h10);
      end
      drain("after_rst");

      // mode latched at w0: later change must be ignored
      q.push_back(32'h12345678);
      q.push_back(32'h9ABCDEF0);
      q.push_back(32'h0F1E2D3C);
      put(32'h12345678, 2'b00, 8'h55);
      put(32'h9ABCDEF0, 2'b01, 8'hFF);
      put(32'h0F1E2D3C, 2'b01, 8'hFF);
      drain("mode_latch");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bmp_pixel_processor.md
# bmp_pixel_processor

Pixel-processing stage downstream of the scheduler. Consumes the pixel-array words the scheduler forwards after the 56-byte BMP header. Applies threshold (mode 01) or brightness (mode 10) per pixel and returns the words, in stream order with `vld_pr`, to the scheduler's FIFO/master path. Words are regrouped internally so that 24-bit pixels straddling 32-bit word boundaries are processed whole.

## Interface

- `DATA_BUS_SIZE`, 32: data bus width. Only 32 is supported, giving 3 words = 12 bytes = 4 pixels per group.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: 01 threshold, 10 brightness, 00/11 pass-through.
- `data_proc` in 8: threshold value (mode 01) or brightness offset (mode 10).
- `data_to_processor` in 32: pixel word; stream byte 0 is at [31:24].
- `scheduler_2_proc_vld` in 1: input word valid. Every valid cycle is accepted; there is no backpressure.
- `done` in 1: level signal, end of file from the scheduler.
- `data_from_processor` out 32: processed word.
- `vld_pr` out 1: output word valid.
- `busy` out 1: high while a partial group is held or output words are pending.

## Operation

- Group bytes b0..b11 come from words w0..w2, with b0 = w0[31:24]. Pixel p uses B = b3p, G = b3p+1, R = b3p+2.
- `mode` and `data_proc` are latched when w0 of a group is accepted. Changes mid-group are ignored.
- Threshold (01):
  - gray = (B + 2G + R) >> 2, computed as a 10-bit sum then truncated to 8 bits.
  - All three bytes of the pixel become 0xFF if gray >= `data_proc`, else 0x00.
- Brightness (10): every byte becomes min(b + `data_proc`, 255), computed with a 9-bit sum then saturated.
- Pass-through (00/11): bytes are unchanged.
- Counters:
  - Word counter `wcnt` runs 0..2.
  - Emit counter `ecnt` runs 0..3 (number of output words pending).
- Group completion: when the word accepted with `wcnt` = 2 arrives, the processed 3-word group is loaded into the output bank on that same edge. Then `ecnt` = 3 and `wcnt` = 0.
- Flush:
  - Triggered when `done` = 1, `scheduler_2_proc_vld` = 0 and `wcnt` ≠ 0.
  - The partial group (1 or 2 words) is processed and loaded, with `ecnt` = `wcnt` and `wcnt` = 0.
  - Only complete pixels are transformed. Trailing bytes of an incomplete pixel pass through unchanged.
- `done` while `wcnt` = 0 has no effect. Because `done` is a level, the flush fires at most once per partial group.
- Row padding bytes are treated as pixel bytes. This is a known limitation.
- Emission: while `ecnt` > 0, the bank presents one word per cycle in order and `ecnt` decrements.
- `busy` = (`wcnt` ≠ 0) | (`ecnt` ≠ 0).

## Timing

- Reset values: `data_from_processor` = 0, `vld_pr` = 0, `busy` = 0, `wcnt` = `ecnt` = 0, bank cleared.
- Reset mid-operation discards the partial group and pending output. `vld_pr` is 0 in the cycle after reset is sampled.
- Latency: third word sampled at edge t → `vld_pr` = 1 with w0 in cycle t..t+1, w1 next, w2 next.
- Flush latency: flush sampled at edge t → first word valid in cycle t..t+1.
- Throughput: one word per cycle sustained. The next group's third word arrives no earlier than edge t+3, when `ecnt` has just reached 0, so there is no overlap and no stall.
- `vld_pr` stays high across back-to-back groups.
- A valid word arriving in the same cycle as `done` is accepted normally. A flush, if needed, occurs on a later cycle while `done` is still high.
- The output count always equals the input count.

## Structure

- Package `bmp_pkg` holds:
  - `MODE_PASS` = 2'b00, `MODE_TH` = 2'b01, `MODE_BR` = 2'b10.
  - `HEADER_BYTES` = 56.
  - `BYTES_PER_PIXEL` = 3, `WORDS_PER_GROUP` = 3, `PIXELS_PER_GROUP` = 4.
- Sub-module `pixel_op`: combinational, maps one 24-bit pixel plus mode/`data_proc` to 24 bits. It is instantiated 4 times, with enables for flush.
- Top level holds the two held input words, the counters, the output bank and the flush logic.

## Test plan

- Threshold, `data_proc` = 0x80; inputs w0 = 0xFFFFFF00, w1 = 0x00000080, w2 = 0x80808080 on cycles 0–2.
  - Outputs on cycles 3–5: 0xFFFFFF00, 0x00000000, 0x00FFFFFF.
  - Gray 96 → 0x00; gray 128 (equal to threshold) → 0xFF.
- Continuous stream: 6 words on consecutive cycles → `vld_pr` high for exactly 6 consecutive cycles, outputs in order.
- Brightness, `data_proc` = 0x10; 3× 0xF5FA0010 → 3× 0xFFFF1020 (saturation checked).
- Flush, threshold 0x80; w0 = 0x80808080, w1 = 0x80808012, then `done` = 1 with valid low.
  - Outputs: 0xFFFFFFFF, 0xFFFF8012 (bytes 6–7 pass through), then `busy` = 0.
  - Holding `done` high afterwards produces nothing further.
- Reset mid-group: 1 word, then `rst` for 1 cycle → `busy` = 0, no `vld_pr`. The next 3 words form a fresh group with correct output.
- Mode change mid-group: group starts in mode 00, `mode` switches to 01 after w0 → all 3 output words equal the inputs.
